// File: rtl/port_wrr_scheduler.sv
// Per-egress-port packet scheduler: per-priority packet counters, WRR / strict-priority selection, one grant per packet.
// Optional anti-starvation guard for strict mode is enabled with `define STARVE_GUARD_EN.
module port_wrr_scheduler #(
    parameter int PRI_NUM      = 8,
    parameter int CNT_WIDTH    = 10,
    parameter int WEIGHT_WIDTH = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wrr_en,
    input  logic [PRI_NUM*WEIGHT_WIDTH-1:0] weights,
    input  logic                            enq_vld,
    input  logic [2:0]                      enq_prior,
    input  logic                            ready,
    input  logic                            rd_done,
    output logic                            sched_vld,
    output logic [2:0]                      sched_prior,
    output logic                            busy,
    output logic [PRI_NUM-1:0]              queue_nonempty,
    output logic                            overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [WEIGHT_WIDTH-1:0] CRD_ZERO = {WEIGHT_WIDTH{1'b0}};
    localparam logic [WEIGHT_WIDTH-1:0] CRD_ONE  = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [CNT_WIDTH-1:0]    cnt_r [PRI_NUM];
    logic                    overflow_r;
    logic                    sched_vld_r;
    logic [2:0]              sched_prior_r;
    logic                    busy_r;
    logic [2:0]              ptr_r;
    logic [WEIGHT_WIDTH-1:0] credit_r;
    logic                    fresh_r;
    logic                    mode_r;

    logic [PRI_NUM-1:0]      nonempty_s;
    logic                    grant_s;
    logic [2:0]              sel_s;
    logic [2:0]              strict_sel_s;
    logic [2:0]              wrr_sel_s;
    logic [WEIGHT_WIDTH-1:0] wrr_credit_nxt_s;
    logic                    fresh_eff_s;
    logic [2:0]              scan_idx_s;
    logic                    overflow_hit_s;

    // A programmed weight of zero still earns one grant per visit.
    function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(
        input logic [PRI_NUM*WEIGHT_WIDTH-1:0] w,
        input logic [2:0]                      q
    );
        logic [WEIGHT_WIDTH-1:0] v;
        v = w[int'(q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        if (v == CRD_ZERO) begin
            return CRD_ONE;
        end else begin
            return v;
        end
    endfunction

    assign sched_vld      = sched_vld_r;
    assign sched_prior    = sched_prior_r;
    assign busy           = busy_r;
    assign overflow       = overflow_r;
    assign queue_nonempty = nonempty_s;

    // Per-queue occupancy flags.
    always_comb begin
        nonempty_s = {PRI_NUM{1'b0}};
        for (int q = 0; q < PRI_NUM; q++) begin
            nonempty_s[q] = (cnt_r[q] != CNT_ZERO);
        end
    end

    assign grant_s     = (state_r == ST_IDLE) && ready && (|nonempty_s);
    assign sel_s       = wrr_en ? wrr_sel_s : strict_sel_s;
    assign fresh_eff_s = fresh_r | (wrr_en != mode_r);

`ifdef STARVE_GUARD_EN
    localparam int                WAIT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};

    logic [WAIT_W-1:0]  wait_r [PRI_NUM];
    logic [PRI_NUM-1:0] starved_s;

    // Queues that have waited out STARVE_LIMIT strict grants.
    always_comb begin
        starved_s = {PRI_NUM{1'b0}};
        for (int q = 0; q < PRI_NUM; q++) begin
            starved_s[q] = nonempty_s[q] && (wait_r[q] >= WAIT_LIMIT);
        end
    end

    // Strict choice: a starved queue pre-empts plain priority order.
    always_comb begin
        strict_sel_s = 3'd0;
        if (|starved_s) begin
            for (int q = PRI_NUM - 1; q >= 0; q--) begin
                if (starved_s[q]) begin
                    strict_sel_s = 3'(q);
                end else begin
                    strict_sel_s = strict_sel_s;
                end
            end
        end else begin
            for (int q = PRI_NUM - 1; q >= 0; q--) begin
                if (nonempty_s[q]) begin
                    strict_sel_s = 3'(q);
                end else begin
                    strict_sel_s = strict_sel_s;
                end
            end
        end
    end

    // Wait counters: age on every strict grant that passes a nonempty queue by.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < PRI_NUM; q++) begin
                wait_r[q] <= {WAIT_W{1'b0}};
            end
        end else begin
            for (int q = 0; q < PRI_NUM; q++) begin
                if (!nonempty_s[q]) begin
                    wait_r[q] <= {WAIT_W{1'b0}};
                end else if (grant_s && !wrr_en) begin
                    if (sel_s == 3'(q)) begin
                        wait_r[q] <= {WAIT_W{1'b0}};
                    end else if (wait_r[q] < WAIT_LIMIT) begin
                        wait_r[q] <= wait_r[q] + WAIT_ONE;
                    end else begin
                        wait_r[q] <= wait_r[q];
                    end
                end else begin
                    wait_r[q] <= wait_r[q];
                end
            end
        end
    end
`else
    // Strict choice: lowest-index nonempty queue.
    always_comb begin
        strict_sel_s = 3'd0;
        for (int q = PRI_NUM - 1; q >= 0; q--) begin
            if (nonempty_s[q]) begin
                strict_sel_s = 3'(q);
            end else begin
                strict_sel_s = strict_sel_s;
            end
        end
    end
`endif

    // WRR choice: stay on ptr while it has credit, else take the next nonempty queue.
    // A fresh pointer (after reset or a mode change) has not loaded credit yet, so the scan includes ptr itself.
    always_comb begin
        wrr_sel_s        = ptr_r;
        wrr_credit_nxt_s = credit_r;
        scan_idx_s       = ptr_r;
        if (!fresh_eff_s && nonempty_s[ptr_r] && (credit_r != CRD_ZERO)) begin
            wrr_credit_nxt_s = credit_r - CRD_ONE;
        end else begin
            for (int off = PRI_NUM; off >= 0; off--) begin
                scan_idx_s = 3'(int'(ptr_r) + off);
                if ((fresh_eff_s || off >= 1) && nonempty_s[scan_idx_s]) begin
                    wrr_sel_s = scan_idx_s;
                end else begin
                    wrr_sel_s = wrr_sel_s;
                end
            end
            wrr_credit_nxt_s = eff_weight(weights, wrr_sel_s) - CRD_ONE;
        end
    end

    // An enqueue overflows only if it lands on a full counter that is not being drained this cycle.
    assign overflow_hit_s = enq_vld && (cnt_r[enq_prior] == CNT_MAX) &&
                            !(grant_s && (sel_s == enq_prior));

    // Packet counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < PRI_NUM; q++) begin
                cnt_r[q] <= CNT_ZERO;
            end
            overflow_r <= 1'b0;
        end else begin
            for (int q = 0; q < PRI_NUM; q++) begin
                if (enq_vld && (enq_prior == 3'(q)) && !(grant_s && (sel_s == 3'(q)))) begin
                    if (cnt_r[q] == CNT_MAX) begin
                        cnt_r[q] <= cnt_r[q];
                    end else begin
                        cnt_r[q] <= cnt_r[q] + CNT_ONE;
                    end
                end else if (grant_s && (sel_s == 3'(q)) && !(enq_vld && (enq_prior == 3'(q)))) begin
                    cnt_r[q] <= cnt_r[q] - CNT_ONE;
                end else begin
                    cnt_r[q] <= cnt_r[q];
                end
            end
            overflow_r <= overflow_r | overflow_hit_s;
        end
    end

    // Grant FSM with registered outputs and WRR pointer/credit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            sched_vld_r   <= 1'b0;
            sched_prior_r <= 3'd0;
            busy_r        <= 1'b0;
            ptr_r         <= 3'd0;
            credit_r      <= CRD_ZERO;
            fresh_r       <= 1'b1;
            mode_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mode_r <= wrr_en;
                    if (grant_s && wrr_en) begin
                        ptr_r    <= wrr_sel_s;
                        credit_r <= wrr_credit_nxt_s;
                        fresh_r  <= 1'b0;
                    end else if (wrr_en != mode_r) begin
                        credit_r <= CRD_ZERO;
                        fresh_r  <= 1'b1;
                    end else begin
                        credit_r <= credit_r;
                        fresh_r  <= fresh_r;
                    end
                    if (grant_s) begin
                        sched_vld_r   <= 1'b1;
                        sched_prior_r <= sel_s;
                        busy_r        <= 1'b1;
                        state_r       <= ST_GRANT;
                    end else begin
                        sched_vld_r   <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    sched_vld_r <= 1'b0;
                    if (rd_done) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    sched_vld_r <= 1'b0;
                    if (rd_done) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    sched_vld_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_wrr_scheduler.sv
// Scoreboard bench for port_wrr_scheduler: directed stimulus pushes expected grant priorities,
// a monitor pops and compares on every sched_vld pulse, a responder returns rd_done.
module tb_port_wrr_scheduler;

`ifdef STARVE_GUARD_EN
    localparam int SL = 4;
`else
    localparam int SL = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrr_en;
    logic [31:0] weights;
    logic        enq_vld;
    logic [2:0]  enq_prior;
    logic        ready;
    logic        rd_done;
    logic        sched_vld;
    logic [2:0]  sched_prior;
    logic        busy;
    logic [7:0]  queue_nonempty;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int grant_cnt = 0;
    int rd_delay = 3;
    bit resp_en = 1'b1;

    port_wrr_scheduler #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .wrr_en(wrr_en), .weights(weights),
        .enq_vld(enq_vld), .enq_prior(enq_prior), .ready(ready), .rd_done(rd_done),
        .sched_vld(sched_vld), .sched_prior(sched_prior), .busy(busy),
        .queue_nonempty(queue_nonempty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enq(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            enq_vld   = 1'b1;
            enq_prior = 3'(p);
            @(negedge clk);
        end
        enq_vld = 1'b0;
    endtask

    task automatic push_seq(input int s[$]);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every grant pulse must match the next expected priority.
    initial begin
        forever begin
            @(negedge clk);
            if (sched_vld === 1'b1) begin
                grant_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got prior %0d, expected no grant (t=%0t)", sched_prior, $time);
                end else begin
                    check("grant_prior", 32'(sched_prior), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Datapath model: busy must stay high until rd_done, then drop.
    initial begin
        rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sched_vld === 1'b1 && resp_en) begin
                for (int i = 0; i < rd_delay; i++) begin
                    check("busy_outstanding", 32'(busy), 32'd1);
                    @(negedge clk);
                end
                rd_done = 1'b1;
                @(negedge clk);
                rd_done = 1'b0;
                check("busy_after_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        int s_wrr[$];
        int s_starve[$];
        int s_ovf[$];
        rst_n = 1'b0; wrr_en = 1'b0; weights = 32'h1111_1111;
        enq_vld = 1'b0; enq_prior = 3'd0; ready = 1'b0;
        repeat (2) @(negedge clk);
        enq(4, 2);
        enq_vld = 1'b1; enq_prior = 3'd1;
        @(negedge clk);
        enq_vld = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_nonempty", 32'(queue_nonempty), 32'h00);
        check("rst_sched_vld", 32'(sched_vld), 32'd0);
        check("rst_sched_prior", 32'(sched_prior), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Strict priority ordering.
        rd_delay = 3;
        enq(5, 2);
        enq(2, 1);
        check("strict_nonempty", 32'(queue_nonempty), 32'h24);
        push_seq('{2, 5, 5});
        ready = 1'b1;
        drain(200);
        ready = 1'b0;

        // ready low blocks grants; rd_done in IDLE is ignored.
        enq(4, 1);
        g0 = grant_cnt;
        repeat (6) @(negedge clk);
        check("noready_grants", grant_cnt, g0);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_nonempty", 32'(queue_nonempty), 32'h10);
        push_seq('{4});
        ready = 1'b1;
        drain(50);
        ready = 1'b0;

        // Same-cycle enqueue and grant on q3.
        rd_delay = 2;
        enq(3, 1);
        push_seq('{3, 3});
        ready = 1'b1;
        enq_vld = 1'b1; enq_prior = 3'd3;
        @(negedge clk);
        enq_vld = 1'b0;
        check("simul_grant", 32'(sched_vld), 32'd1);
        check("simul_q3_kept", 32'(queue_nonempty[3]), 32'd1);
        drain(50);
        check("simul_empty", 32'(queue_nonempty), 32'h00);
        ready = 1'b0;

        // WRR q0=3, q1=1, then q1=0 (behaves as 1).
        wrr_en = 1'b1;
        rd_delay = 1;
        s_wrr = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        weights = 32'h1111_1113;
        enq(0, 6);
        enq(1, 6);
        push_seq(s_wrr);
        ready = 1'b1;
        drain(300);
        ready = 1'b0;
        weights = 32'h1111_1103;
        enq(0, 6);
        enq(1, 6);
        push_seq(s_wrr);
        ready = 1'b1;
        drain(300);
        ready = 1'b0;

        // Strict with q7 waiting behind a busy q0.
        wrr_en = 1'b0;
`ifdef STARVE_GUARD_EN
        s_starve = '{0, 0, 0, 0, 7, 0, 0};
`else
        s_starve = '{0, 0, 0, 0, 0, 0, 7};
`endif
        enq(0, 6);
        enq(7, 1);
        push_seq(s_starve);
        ready = 1'b1;
        drain(300);
        ready = 1'b0;

        // Asynchronous reset while waiting for rd_done.
        resp_en = 1'b0;
        enq(1, 1);
        enq(6, 1);
        push_seq('{1});
        ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        ready = 1'b0;
        check("wait_grant_seen", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_nonempty", 32'(queue_nonempty), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        // Counter saturation at 1023 with sticky overflow.
        rd_delay = 0;
        enq(6, 1023);
        check("ovf_at_full", 32'(overflow), 32'd0);
        enq(6, 1);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 1023; i++) s_ovf.push_back(6);
        push_seq(s_ovf);
        ready = 1'b1;
        drain(5000);
        ready = 1'b0;
        repeat (4) @(negedge clk);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_drained", 32'(queue_nonempty), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_wrr_scheduler.md
Name: port_wrr_scheduler

Overview:
- Per-output-port packet scheduler for the hydra switch.
- Tracks how many complete packets are queued at each of 8 priority levels for one egress port.
- Chooses which priority queue the read datapath serves next, using either weighted round robin or strict priority.
- Issues one read grant per packet and holds until the datapath reports packet completion (eop).

Parameters:
- PRI_NUM, 8, number of priority queues; prior field width is 3.
- CNT_WIDTH, 10, width of each per-queue packet counter.
- WEIGHT_WIDTH, 4, width of each WRR weight.
- STARVE_LIMIT, 16, grant count after which a waiting queue is forced (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrr_en  in  1  1 = weighted round robin, 0 = strict priority (prior 0 highest)
- weights  in  PRI_NUM*WEIGHT_WIDTH  weight of queue q at bits [q*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- enq_vld  in  1  one-cycle pulse: one complete packet stored for this port
- enq_prior  in  3  priority of the enqueued packet
- ready  in  1  downstream egress can accept a new packet
- rd_done  in  1  one-cycle pulse: datapath emitted eop of the granted packet
- sched_vld  out  1  one-cycle grant pulse
- sched_prior  out  3  granted queue, valid while sched_vld=1
- busy  out  1  a grant is outstanding
- queue_nonempty  out  PRI_NUM  bit q = counter q is nonzero
- overflow  out  1  sticky; set when an enqueue hits a full counter

Behaviour:
- Reset values: all counters 0; sched_vld=0; sched_prior=0; busy=0; overflow=0; RR pointer=0; credit=0; state IDLE. An asynchronous reset mid-packet drops the outstanding grant without a completion.
- Counters: enq_vld increments cnt[enq_prior].
  - A grant decrements cnt[sched_prior] in the grant cycle.
  - Enqueue and grant on the same queue in the same cycle: net unchanged.
  - Enqueue to a counter at 2^CNT_WIDTH-1: counter holds, overflow sets and stays set until reset.
- queue_nonempty is combinational from the counters.
- States:
  - IDLE: if ready=1 and any queue is nonempty, select a queue. Next edge: sched_vld=1, sched_prior=selected, counter decremented, busy=1, go to GRANT. Otherwise stay.
  - GRANT: sched_vld returns to 0 next edge; go to WAIT. If rd_done=1 in this cycle, go directly to IDLE.
  - WAIT: stay until rd_done=1, then busy=0 and go to IDLE next edge.
  - rd_done in IDLE is ignored.
- Latency: with ready=1 and a nonempty queue, grant appears 1 cycle later. Back-to-back grants are at minimum 2 cycles apart after rd_done.
- Strict mode: select the lowest-index nonempty queue.
- WRR mode:
  - credit[q] starts at weights[q] (a weight of 0 is treated as 1) when the pointer moves to q.
  - If queue[ptr] is nonempty and credit is greater than 0: grant ptr and decrement credit.
  - Otherwise advance ptr to the next nonempty queue, with wrap 7→0, load its credit, and grant it in the same decision.
  - After the last credit is used, ptr advances in the next decision.
  - If no queue is nonempty, ptr holds.
- A wrr_en change is sampled only in IDLE. Switching modes resets credit for the current ptr.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined (applies in strict mode only):
  - A per-queue wait counter increments for each grant issued while that queue is nonempty but not granted.
  - The counter clears when that queue is granted or becomes empty.
  - A queue whose wait counter reaches STARVE_LIMIT is granted next, ahead of higher priorities.
  - If several queues qualify, the lowest index wins.
- Undefined: pure strict priority; no wait counters are synthesised.

Test Plan:
- Reset with enq_vld pulses around rst_n → all counters 0, sched_vld=0, overflow=0 after release.
- Strict: enqueue 2 packets at prior 5 and 1 at prior 2, hold ready=1, rd_done 3 cycles after each grant → grants in order 2,5,5; busy high between each grant and its rd_done.
- WRR: weights q0=3, q1=1, all others 1; 6 packets each in q0 and q1 → grant sequence 0,0,0,1,0,0,0,1,…; weight 0 behaves as 1.
- Simultaneous enq_vld and grant on q3 with cnt=1 → count stays 1 and a second grant follows. Enqueue 1024 packets with CNT_WIDTH=10 → overflow=1 and counter=1023.
- ready=0 with queues nonempty → no sched_vld. rd_done pulsed in IDLE → no state change. rst_n low during WAIT → busy=0 immediately.
- STARVE_GUARD_EN, STARVE_LIMIT=4: continuously refill q0 while q7 holds 1 packet → q7 granted as the 5th grant; without the macro, q7 is never granted while q0 stays nonempty.
